// File: rtl/wrr_grant_engine.sv
// wrr_grant_engine: weighted round-robin grant engine for a 4-master fabric.
// Each master bids with a 4-bit weight (0 = no request). Waiting masters
// accumulate credit in a saturating balance. The eligible master with the
// highest balance+bid wins. A rotating pointer breaks ties. Grants are
// registered and one-hot, and every release passes through at least one idle
// cycle with grant=0.
// Optional feature macro: WRR_HOLD_LIMIT_EN forces a release after MAX_HOLD
// transfer cycles in one tenure.
module wrr_grant_engine #(
  parameter int BAL_W    = 10,
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] bid0,
  input  logic [3:0] bid1,
  input  logic [3:0] bid2,
  input  logic [3:0] bid3,
  input  logic [3:0] xfr,
  output logic [3:0] grant,
  output logic       busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [BAL_W:0] BAL_MAX = {1'b0, {BAL_W{1'b1}}};

  state_t           state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [7:0]       hold_cnt_q, hold_cnt_d;
  logic [3:0]       grant_q, grant_d;
  logic             busy_q, busy_d;
  logic [BAL_W-1:0] bal_q [4];
  logic [BAL_W-1:0] bal_d [4];

  logic [3:0]       bid_s [4];
  logic [BAL_W:0]   score_s [4];
  logic             win_found_s;
  logic [1:0]       win_idx_s;
  logic [BAL_W:0]   win_score_s;
  logic             release_s;
  logic             launch_s;

  // Gather bids into an array and form full-width scores (balance + bid).
  always_comb begin
    bid_s[0] = bid0;
    bid_s[1] = bid1;
    bid_s[2] = bid2;
    bid_s[3] = bid3;
    for (int i = 0; i < 4; i++) begin
      score_s[i] = {1'b0, bal_q[i]} + {{(BAL_W-3){1'b0}}, bid_s[i]};
    end
  end

  // Pick the eligible master with the highest score; scanning from ptr with a
  // strict comparison makes the first tied master in rotation order win.
  always_comb begin
    logic [1:0] idx_v;
    win_found_s = 1'b0;
    win_idx_s   = 2'd0;
    win_score_s = '0;
    idx_v       = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx_v = ptr_q + 2'(k);
      if ((bid_s[idx_v] != 4'd0) && (!win_found_s || (score_s[idx_v] > win_score_s))) begin
        win_found_s = 1'b1;
        win_idx_s   = idx_v;
        win_score_s = score_s[idx_v];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Decide whether the current tenure ends on this edge.
`ifdef WRR_HOLD_LIMIT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  always_comb begin
    release_s = (bid_s[owner_q] == 4'd0) ||
                (xfr[owner_q] && (hold_cnt_q == HOLD_LAST));
  end
`else
  always_comb begin
    release_s = (bid_s[owner_q] == 4'd0);
  end
`endif

  // Grant FSM next-state: arbitrate in IDLE, hold or release in GRANT.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    grant_d    = grant_q;
    launch_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found_s) begin
          state_d    = GRANT;
          grant_d    = 4'b0001 << win_idx_s;
          owner_d    = win_idx_s;
          ptr_d      = win_idx_s + 2'd1;
          hold_cnt_d = 8'd0;
          launch_s   = 1'b1;
        end else begin
          grant_d = 4'b0000;
        end
      end
      GRANT: begin
        if (release_s) begin
          state_d = IDLE;
          grant_d = 4'b0000;
        end else if (xfr[owner_q] && (hold_cnt_q != 8'd255)) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end else begin
          hold_cnt_d = hold_cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
      end
    endcase
    busy_d = (grant_d != 4'b0000);
  end

  // Credit update: winner clears, owner freezes, waiters accumulate with
  // saturation, and a withdrawn bid forfeits its credit.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      if (launch_s && (win_idx_s == 2'(i))) begin
        bal_d[i] = '0;
      end else if ((state_q == GRANT) && (owner_q == 2'(i))) begin
        bal_d[i] = bal_q[i];
      end else if (bid_s[i] != 4'd0) begin
        if (score_s[i] > BAL_MAX) begin
          bal_d[i] = BAL_MAX[BAL_W-1:0];
        end else begin
          bal_d[i] = score_s[i][BAL_W-1:0];
        end
      end else begin
        bal_d[i] = '0;
      end
    end
  end

  // State registers with asynchronous reset so grant drops without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= 2'd0;
      ptr_q      <= 2'd0;
      hold_cnt_q <= 8'd0;
      grant_q    <= 4'b0000;
      busy_q     <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        bal_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      for (int i = 0; i < 4; i++) begin
        bal_q[i] <= bal_d[i];
      end
    end
  end

  assign grant = grant_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_wrr_grant_engine.sv
// Directed testbench for wrr_grant_engine (default build; the hold-limit
// scenario is compiled when WRR_HOLD_LIMIT_EN is defined).
module tb_wrr_grant_engine;

  logic       clk;
  logic       rst;
  logic [3:0] bid [4];
  logic [3:0] xfr;
  logic [3:0] grant;
  logic       busy;

  int n_vec;
  int n_err;

  wrr_grant_engine #(.BAL_W(10), .MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .bid0  (bid[0]),
    .bid1  (bid[1]),
    .bid2  (bid[2]),
    .bid3  (bid[3]),
    .xfr   (xfr),
    .grant (grant),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_bids();
    for (int i = 0; i < 4; i++) bid[i] = 4'd0;
    xfr = 4'b0000;
  endtask

  task automatic do_reset();
    clear_bids();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_bids();
    #1 rst = 1'b1;
    bid[0] = 4'd5;
    #1;
    n_vec++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async grant=%b busy=%b expected 0000/0", grant, busy);
    end
    step();
    n_vec++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_held grant=%b busy=%b expected 0000/0", grant, busy);
    end
    bid[0] = 4'd0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    bid[2] = 4'd4;
    step();
    n_vec++;
    if (grant !== 4'b0100 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_grant grant=%b busy=%b expected 0100/1", grant, busy);
    end
    bid[2] = 4'd0;
    step();
    n_vec++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_release grant=%b busy=%b expected 0000/0", grant, busy);
    end
    step();
    n_vec++;
    if (grant !== 4'b0000) begin
      n_err++;
      $display("FAIL single_dead grant=%b expected 0000", grant);
    end
  endtask

  task automatic test_equal_rotation();
    logic [3:0] exp_g;
    do_reset();
    for (int i = 0; i < 4; i++) bid[i] = 4'd1;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      step();
      n_vec++;
      if (grant !== exp_g) begin
        n_err++;
        $display("FAIL rotation_grant%0d grant=%b expected %b", k, grant, exp_g);
      end
      bid[k % 4] = 4'd0;
      step();
      n_vec++;
      if (grant !== 4'b0000) begin
        n_err++;
        $display("FAIL rotation_dead%0d grant=%b expected 0000", k, grant);
      end
      bid[k % 4] = 4'd1;
    end
    clear_bids();
    step();
  endtask

  task automatic test_weighted();
    do_reset();
    bid[0] = 4'd1;
    bid[3] = 4'd8;
    step();
    n_vec++;
    if (grant !== 4'b1000 || dut.bal_q[3] !== 10'd0) begin
      n_err++;
      $display("FAIL weighted_win grant=%b bal3=%0d expected 1000/0", grant, dut.bal_q[3]);
    end
    for (int c = 1; c <= 4; c++) begin
      n_vec++;
      if (dut.bal_q[0] !== 10'(c) || grant !== 4'b1000) begin
        n_err++;
        $display("FAIL weighted_bal0_%0d bal0=%0d grant=%b expected %0d/1000", c, dut.bal_q[0], grant, c);
      end
      if (c < 4) step();
    end
    bid[3] = 4'd0;
    step();
    n_vec++;
    if (grant !== 4'b0000) begin
      n_err++;
      $display("FAIL weighted_release grant=%b expected 0000", grant);
    end
    step();
    n_vec++;
    if (grant !== 4'b0001) begin
      n_err++;
      $display("FAIL weighted_next grant=%b expected 0001", grant);
    end
    clear_bids();
    step();
    step();
  endtask

  task automatic test_saturation();
    do_reset();
    bid[0] = 4'd1;
    step();
    bid[1] = 4'd15;
    for (int c = 1; c <= 120; c++) begin
      step();
      if (c == 10) begin
        n_vec++;
        if (dut.bal_q[1] !== 10'd150) begin
          n_err++;
          $display("FAIL sat_partial bal1=%0d expected 150", dut.bal_q[1]);
        end
      end
      if (c == 69) begin
        n_vec++;
        if (dut.bal_q[1] !== 10'd1023) begin
          n_err++;
          $display("FAIL sat_reach bal1=%0d expected 1023", dut.bal_q[1]);
        end
      end
    end
    n_vec++;
    if (dut.bal_q[1] !== 10'd1023 || grant !== 4'b0001) begin
      n_err++;
      $display("FAIL sat_hold bal1=%0d grant=%b expected 1023/0001", dut.bal_q[1], grant);
    end
    bid[0] = 4'd0;
    step();
    n_vec++;
    if (grant !== 4'b0000 || dut.bal_q[1] !== 10'd1023) begin
      n_err++;
      $display("FAIL sat_release grant=%b bal1=%0d expected 0000/1023", grant, dut.bal_q[1]);
    end
    step();
    n_vec++;
    if (grant !== 4'b0010 || dut.bal_q[1] !== 10'd0) begin
      n_err++;
      $display("FAIL sat_next grant=%b bal1=%0d expected 0010/0", grant, dut.bal_q[1]);
    end
    clear_bids();
    step();
  endtask

`ifdef WRR_HOLD_LIMIT_EN
  task automatic test_hold_limit();
    do_reset();
    bid[0] = 4'd2;
    bid[1] = 4'd1;
    xfr    = 4'b0001;
    for (int e = 1; e <= 4; e++) begin
      step();
      n_vec++;
      if (grant !== 4'b0001) begin
        n_err++;
        $display("FAIL hold_tenure%0d grant=%b expected 0001", e, grant);
      end
    end
    step();
    n_vec++;
    if (grant !== 4'b0000) begin
      n_err++;
      $display("FAIL hold_release grant=%b expected 0000", grant);
    end
    step();
    n_vec++;
    if (grant !== 4'b0010) begin
      n_err++;
      $display("FAIL hold_next grant=%b expected 0010", grant);
    end
    clear_bids();
    step();
  endtask
`endif

  task automatic test_async_reset();
    do_reset();
    bid[2] = 4'd3;
    step();
    n_vec++;
    if (grant !== 4'b0100) begin
      n_err++;
      $display("FAIL areset_pre grant=%b expected 0100", grant);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL areset_mid grant=%b busy=%b expected 0000/0", grant, busy);
    end
    step();
    clear_bids();
    bid[3] = 4'd1;
    rst = 1'b0;
    step();
    n_vec++;
    if (grant !== 4'b1000 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL areset_first grant=%b busy=%b expected 1000/1", grant, busy);
    end
    clear_bids();
    step();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_single();
    test_equal_rotation();
    test_weighted();
`ifdef WRR_HOLD_LIMIT_EN
    test_hold_limit();
`else
    test_saturation();
`endif
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
